// File: rtl/valid_ready_fifo_if.sv
// Stream bundle around valid_ready_fifo: producer side (in_*), consumer side (out_*)
// and the occupancy status the FIFO reports back.
interface valid_ready_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a word moves on a rising edge exactly when valid && ready are both high;
  // the offering side keeps valid and data stable until that edge.
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         count;
  logic                  almost_full;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full
  );
endinterface

// File: rtl/valid_ready_fifo.sv
// Circular FIFO decoupling a valid/ready producer from a valid/ready consumer,
// with occupancy count, almost-full flag and synchronous flush.
module valid_ready_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  valid_ready_fifo_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  in_ready;
  logic                  out_valid;
  logic                  push;
  logic                  pop;

  // Both flow-control outputs come from registered state only, so a full FIFO
  // cannot accept a word in the same cycle it gives one away.
  assign in_ready  = !reset && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AFULL_CNT);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap so DEPTH need not be a power of two.
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; flush/reset only make old words unreachable.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= bus.in_data;
  end
endmodule

// File: tb/tb_valid_ready_fifo.sv
// Bench for valid_ready_fifo: a DEPTH=4 instance for directed scenarios and a
// DEPTH=3 instance for long random streaming, both checked against a queue model.
module tb_valid_ready_fifo;
  localparam int DW = 32;
  localparam int NI = 2;
  localparam int N_STREAM = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] in_data_s  [NI];
  logic          in_valid_s [NI];
  logic          out_ready_s[NI];
  logic          flush_s    [NI];
  bit            acc_s      [NI];
  int            n_out      [NI];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUTs, reference model, scoreboard ----------------
  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int D  = (g == 0) ? 4 : 3;
    localparam int AF = D - 1;

    valid_ready_fifo_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    valid_ready_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AFULL_LEVEL(AF)) u_dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush_s[g]),
      .bus   (bus.slave)
    );

    assign bus.in_data   = in_data_s[g];
    assign bus.in_valid  = in_valid_s[g];
    assign bus.out_ready = out_ready_s[g];

    // Model: the FIFO is just the ordered list of accepted, not yet consumed words.
    logic [DW-1:0] exp_q[$];
    int occ_pre = 0;

    // Monitor: compare visible state to the list, pop on a consumer handshake.
    always @(negedge clk) begin
      if (mon_en) begin
        occ_pre = exp_q.size();
        chk($sformatf("count[%0d]", g), DW'(bus.count), DW'(occ_pre));
        chk($sformatf("in_ready[%0d]", g), bus.in_ready, (!reset && occ_pre != D));
        chk($sformatf("out_valid[%0d]", g), bus.out_valid, (occ_pre != 0));
        chk($sformatf("almost_full[%0d]", g), bus.almost_full, (occ_pre >= AF));
        if (occ_pre != 0) begin
          chk($sformatf("out_data[%0d]", g), bus.out_data, exp_q[0]);
          if (out_ready_s[g] && !reset && !flush_s[g]) begin
            void'(exp_q.pop_front());
            n_out[g]++;
          end
        end
      end
    end

    // Stimulus side: a word offered while the list has room becomes expected output.
    always @(posedge clk) begin
      acc_s[g] = 1'b0;
      if (reset || flush_s[g]) begin
        exp_q.delete();
      end else if (mon_en && in_valid_s[g] && occ_pre != D) begin
        exp_q.push_back(in_data_s[g]);
        acc_s[g] = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int g, input logic [DW-1:0] d, input int budget);
    in_data_s[g]  = d;
    in_valid_s[g] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      step();
      if (acc_s[g]) begin
        in_valid_s[g] = 1'b0;
        return;
      end
    end
    in_valid_s[g] = 1'b0;
    n_cmp++;
    n_bad++;
    $display("FAIL push_timeout[%0d]: word %h not accepted within %0d cycles", g, d, budget);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      in_data_s[g]   = '0;
      in_valid_s[g]  = 1'b0;
      out_ready_s[g] = 1'b0;
      flush_s[g]     = 1'b0;
      n_out[g]       = 0;
    end
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    chk("reset_in_ready", g_i[0].bus.in_ready, 1'b0);
    chk("reset_count", DW'(g_i[0].bus.count), '0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("release_in_ready", g_i[0].bus.in_ready, 1'b1);
    step();

    // Fill and drain
    for (int i = 0; i < 4; i++) push_word(0, DW'(32'hA0 + i), 10);
    @(negedge clk);
    chk("fill_count", DW'(g_i[0].bus.count), DW'(4));
    chk("fill_in_ready", g_i[0].bus.in_ready, 1'b0);
    chk("fill_afull", g_i[0].bus.almost_full, 1'b1);
    step();
    out_ready_s[0] = 1'b1;
    repeat (4) step();
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    chk("drain_count", DW'(g_i[0].bus.count), '0);
    chk("drain_out_valid", g_i[0].bus.out_valid, 1'b0);
    chk("drain_n_out", DW'(n_out[0]), DW'(4));
    step();

    // Latency of a single word into an empty FIFO
    push_word(0, DW'(32'h55), 10);
    @(negedge clk);
    chk("lat_out_valid", g_i[0].bus.out_valid, 1'b1);
    chk("lat_out_data", g_i[0].bus.out_data, DW'(32'h55));
    step();
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;

    // Full with simultaneous pop: the pop must not open a push slot that cycle
    for (int i = 0; i < 4; i++) push_word(0, DW'(32'h10 + i), 10);
    in_data_s[0]   = DW'(32'hBB);
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    chk("fullpop_count", DW'(g_i[0].bus.count), DW'(3));
    step();
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    chk("fullpop_refill", DW'(g_i[0].bus.count), DW'(4));
    step();
    out_ready_s[0] = 1'b1;
    repeat (4) step();
    out_ready_s[0] = 1'b0;

    // Flush mid-stream discards the offered word and the pending pop
    push_word(0, DW'(32'h21), 10);
    push_word(0, DW'(32'h22), 10);
    flush_s[0]     = 1'b1;
    in_data_s[0]   = DW'(32'hCC);
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    step();
    flush_s[0]     = 1'b0;
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    chk("flush_count", DW'(g_i[0].bus.count), '0);
    chk("flush_out_valid", g_i[0].bus.out_valid, 1'b0);
    step();
    push_word(0, DW'(32'hDD), 10);
    @(negedge clk);
    chk("flush_next_data", g_i[0].bus.out_data, DW'(32'hDD));
    step();
    out_ready_s[0] = 1'b1;
    step();
    out_ready_s[0] = 1'b0;

    // Random streaming through the DEPTH=3 instance
    fork
      begin
        for (int i = 0; i < N_STREAM; i++) begin
          while ($urandom_range(0, 1) == 0) step();
          push_word(1, DW'($urandom), 200);
        end
      end
      begin
        for (int c = 0; c < 20000 && n_out[1] < N_STREAM; c++) begin
          out_ready_s[1] = ($urandom_range(0, 1) == 1);
          step();
        end
        out_ready_s[1] = 1'b0;
      end
    join
    chk("stream_n_out", DW'(n_out[1]), DW'(N_STREAM));

    // Reset mid-stream, held for two cycles
    for (int i = 0; i < 3; i++) push_word(0, DW'(32'h30 + i), 10);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst_in_ready", g_i[0].bus.in_ready, 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", g_i[0].bus.in_ready, 1'b1);
    chk("rst_out_valid", g_i[0].bus.out_valid, 1'b0);
    chk("rst_count", DW'(g_i[0].bus.count), '0);
    step();
    push_word(0, DW'(32'h77), 10);
    out_ready_s[0] = 1'b1;
    repeat (2) step();
    out_ready_s[0] = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
